compensation_sum_sequencer: RTL and testbench
=============================================

COMPENSATION_SUM_SEQUENCER -- requirements
Module: compensation_sum_sequencer

Interface
REQ-001 Parameter LANES, 8, number of systolic-array columns and accumulator depth.
REQ-002 Parameter COMP_IN_WIDTH, 9, signed width of one per-lane compensation product.
REQ-003 Parameter COMPENSATION_PARTIAL_SUM_WIDTH, 13, signed width of accumulated sum and of Compensation_Sum_in.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 comp_valid  in  1  comp_data beat offered.
REQ-007 comp_ready  out  1  beat accepted when comp_valid and comp_ready are both high.
REQ-008 comp_last  in  1  qualifies the accepted beat as the final beat of a tile.
REQ-009 comp_data  in  LANES*COMP_IN_WIDTH  signed lane values; lane i at bits [i*COMP_IN_WIDTH +: COMP_IN_WIDTH].
REQ-010 clear  in  1  synchronous abort: discard sums, return to ACC.
REQ-011 CACC_Write_enable  out  1  shift-enable to the compensation accumulator.
REQ-012 Compensation_Sum_in  out  COMPENSATION_PARTIAL_SUM_WIDTH  value shifted into the accumulator.
REQ-013 busy  out  1  high in DRAIN and DONE.
REQ-014 done  out  1  one-cycle pulse after the last write of a tile.

Function
REQ-015 FSM states ACC, DRAIN, DONE; the FSM SHALL enter ACC after reset.
REQ-016 ACC: comp_ready=1, CACC_Write_enable=0; per accepted beat, acc[i] <= sat(acc[i] + sext(lane i)) for all lanes in parallel.
REQ-017 sat(): signed add at COMPENSATION_PARTIAL_SUM_WIDTH+1 bits, clamped to [-4096, +4095] for the default width.
REQ-018 An accepted beat with comp_last=1 SHALL be accumulated, then ACC->DRAIN on the next edge with cnt=0.
REQ-019 DRAIN: comp_ready=0; CACC_Write_enable=1 each cycle; Compensation_Sum_in = acc[LANES-1-cnt]; cnt increments each cycle.
REQ-020 Drain order lane LANES-1 first, lane 0 last, so accumulator entry i holds lane i after the eighth shift.
REQ-021 DRAIN->DONE when cnt=LANES-1; CACC_Write_enable SHALL be high for exactly LANES consecutive cycles.
REQ-022 DONE: done=1 and CACC_Write_enable=0 for one cycle; all acc cleared to 0; DONE->ACC unconditionally.
REQ-023 Latency: last beat accepted at edge T -> writes in cycles T+1..T+8 -> done high in cycle T+9 -> comp_ready high in cycle T+10.
REQ-024 comp_valid while comp_ready=0 SHALL be ignored; sender holds data (standard valid/ready).
REQ-025 clear in any state SHALL, at the next edge, zero acc and cnt and enter ACC; CACC_Write_enable drops immediately after that edge; done is not pulsed.
REQ-026 clear and an accepted beat in the same cycle: clear wins and the beat is dropped.
REQ-027 Compensation_Sum_in SHALL be 0 whenever CACC_Write_enable=0.

Reset
REQ-028 rst low at an edge: state=ACC, cnt=0, all acc=0; in the following cycle comp_ready=1, CACC_Write_enable=0, Compensation_Sum_in=0, busy=0, done=0.
REQ-029 Reset mid-DRAIN SHALL abort the drain with no further writes; the accumulator contents are not repaired.

Structure
REQ-030 Shared package holds LANES, COMP_IN_WIDTH, COMPENSATION_PARTIAL_SUM_WIDTH, saturation bounds and the state enum.
REQ-031 One sub-module, comp_sat_adder (signed sign-extend, add and saturate), instantiated LANES times; the FSM and counter reside in the top.

Verification
REQ-032 Single-beat tile, lanes 0..7 = 1..8, comp_last=1 -> Compensation_Sum_in 8,7,...,1 over 8 write cycles; done one cycle later.
REQ-033 Three beats, all lanes +100 -> every drained value 300; comp_ready=0 for exactly 9 cycles.
REQ-034 Saturation: 20 beats, all lanes +255 -> 4095; 20 beats, all lanes -256 -> -4096.
REQ-035 clear asserted on the 4th DRAIN cycle -> exactly 4 writes, no done, next tile drains sums computed from zero.
REQ-036 rst low during ACC after 2 beats -> the next single-beat tile drains only its own values.
REQ-037 comp_valid held high through DRAIN with random data -> no accumulation until comp_ready returns high.

Source files
------------

// File: rtl/compensation_sum_sequencer_pkg.sv
// Shared constants and state encoding for the compensation sum sequencer.
// Holds the default lane count, input/sum widths, the saturation bounds of
// the accumulated sum, and the three-state FSM enum.
package compensation_sum_sequencer_pkg;
  localparam int LANES                          = 8;
  localparam int COMP_IN_WIDTH                  = 9;
  localparam int COMPENSATION_PARTIAL_SUM_WIDTH = 13;

  localparam int SAT_MAX = (2 ** (COMPENSATION_PARTIAL_SUM_WIDTH - 1)) - 1;  //  4095
  localparam int SAT_MIN = -(2 ** (COMPENSATION_PARTIAL_SUM_WIDTH - 1));     // -4096

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/compensation_sum_sequencer_sat.sv
// comp_sat_adder: one lane of the accumulator update.
// Sign-extends a lane product, adds it to the running sum one bit wider
// than the sum, and clamps the result into the signed sum range.
// Ports:
//   i_acc  - current signed partial sum (SUM_W bits)
//   i_val  - signed lane product (IN_W bits)
//   o_sum  - saturated signed sum (SUM_W bits)
module comp_sat_adder
  import compensation_sum_sequencer_pkg::*;
#(
  parameter int IN_W  = compensation_sum_sequencer_pkg::COMP_IN_WIDTH,
  parameter int SUM_W = compensation_sum_sequencer_pkg::COMPENSATION_PARTIAL_SUM_WIDTH
) (
  input  logic [SUM_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_val,
  output logic [SUM_W-1:0] o_sum
);
  logic [SUM_W:0] w_acc_x;
  logic [SUM_W:0] w_val_x;
  logic [SUM_W:0] w_raw;

  assign w_acc_x = {i_acc[SUM_W-1], i_acc};
  assign w_val_x = {{(SUM_W + 1 - IN_W){i_val[IN_W-1]}}, i_val};
  assign w_raw   = w_acc_x + w_val_x;

  // The two top bits of the widened sum disagree only on overflow; the
  // extra bit then carries the true sign and picks the bound.
  always_comb begin
    o_sum = w_raw[SUM_W-1:0];
    if (w_raw[SUM_W] != w_raw[SUM_W-1])
      o_sum = w_raw[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  end
endmodule

// File: rtl/compensation_sum_sequencer.sv
// compensation_sum_sequencer: accumulates per-lane compensation products
// over the beats of a tile, then shifts the LANES sums into the
// compensation accumulator, highest lane first, and pulses done.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   comp_valid/ready    - beat handshake; ready only while accumulating
//   comp_last           - marks the final beat of a tile
//   comp_data           - LANES signed lane products, lane i at [i*W +: W]
//   clear               - synchronous abort back to accumulate, sums zeroed
//   CACC_Write_enable   - shift-enable to the accumulator (LANES cycles)
//   Compensation_Sum_in - value shifted in; zero when not writing
//   busy, done          - draining/done indication, one-cycle done pulse
module compensation_sum_sequencer
  import compensation_sum_sequencer_pkg::*;
#(
  parameter int LANES                          = compensation_sum_sequencer_pkg::LANES,
  parameter int COMP_IN_WIDTH                  = compensation_sum_sequencer_pkg::COMP_IN_WIDTH,
  parameter int COMPENSATION_PARTIAL_SUM_WIDTH = compensation_sum_sequencer_pkg::COMPENSATION_PARTIAL_SUM_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      comp_valid,
  output logic                                      comp_ready,
  input  logic                                      comp_last,
  input  logic [LANES*COMP_IN_WIDTH-1:0]            comp_data,
  input  logic                                      clear,
  output logic                                      CACC_Write_enable,
  output logic [COMPENSATION_PARTIAL_SUM_WIDTH-1:0] Compensation_Sum_in,
  output logic                                      busy,
  output logic                                      done
);
  localparam int SUM_W = COMPENSATION_PARTIAL_SUM_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e                       r_state;
  state_e                       w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             w_rd_idx;
  logic [LANES-1:0][SUM_W-1:0]  r_acc;
  logic [LANES-1:0][SUM_W-1:0]  w_sum;
  logic                         w_accept;
  logic                         w_cnt_last;

  // Accept is derived from state directly rather than from comp_ready so
  // the handshake does not loop through the output decode.
  assign w_accept   = comp_valid && (r_state == ST_ACC);
  assign w_cnt_last = (r_cnt == CNT_W'(LANES - 1));
  assign w_rd_idx   = CNT_W'(LANES - 1) - r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    comp_sat_adder #(
      .IN_W  (COMP_IN_WIDTH),
      .SUM_W (SUM_W)
    ) u_add (
      .i_acc (r_acc[g]),
      .i_val (comp_data[g*COMP_IN_WIDTH +: COMP_IN_WIDTH]),
      .o_sum (w_sum[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) r_state <= ST_ACC;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt         = r_state;
    comp_ready          = 1'b0;
    CACC_Write_enable   = 1'b0;
    Compensation_Sum_in = '0;
    busy                = 1'b0;
    done                = 1'b0;
    case (r_state)
      ST_ACC: begin
        comp_ready = 1'b1;
        if (comp_valid && comp_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy                = 1'b1;
        CACC_Write_enable   = 1'b1;
        Compensation_Sum_in = r_acc[w_rd_idx];
        if (w_cnt_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Clear shares the reset path, so a beat arriving with clear is dropped.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) r_acc <= w_sum;
          r_cnt <= '0;
        end
        ST_DRAIN: r_cnt <= r_cnt + 1'b1;
        ST_DONE: begin
          r_cnt <= '0;
          r_acc <= '0;
        end
        default: begin
          r_cnt <= '0;
          r_acc <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_compensation_sum_sequencer.sv
module tb_compensation_sum_sequencer;
  localparam int LANES = 8;
  localparam int IW    = 9;
  localparam int SW    = 13;
  localparam int DW    = LANES * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          comp_valid;
  logic          comp_ready;
  logic          comp_last;
  logic [DW-1:0] comp_data;
  logic          clear;
  logic          CACC_Write_enable;
  logic [SW-1:0] Compensation_Sum_in;
  logic          busy;
  logic          done;

  compensation_sum_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .comp_valid          (comp_valid),
    .comp_ready          (comp_ready),
    .comp_last           (comp_last),
    .comp_data           (comp_data),
    .clear               (clear),
    .CACC_Write_enable   (CACC_Write_enable),
    .Compensation_Sum_in (Compensation_Sum_in),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int m_acc  [LANES];
  int exp_arr[LANES];

  typedef struct {
    string name;
    int    nbeats;
    int    base;
    int    step;
    int    exp_base;
    int    exp_step;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int s);
    if (s > 4095)  return 4095;
    if (s < -4096) return -4096;
    return s;
  endfunction

  function automatic int lane_of(input logic [DW-1:0] d, input int i);
    logic signed [IW-1:0] t;
    t = d[i*IW +: IW];
    return int'(t);
  endfunction

  function automatic logic [DW-1:0] pack_ramp(input int base, input int step);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[i*IW +: IW] = IW'(base + step * i);
    return d;
  endfunction

  function automatic void model_beat(input logic [DW-1:0] d);
    for (int i = 0; i < LANES; i++) m_acc[i] = sat(m_acc[i] + lane_of(d, i));
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < LANES; i++) m_acc[i] = 0;
  endfunction

  function automatic void expect_from_model();
    for (int i = 0; i < LANES; i++) exp_arr[i] = m_acc[i];
    model_zero();
  endfunction

  function automatic int sum_out();
    return int'($signed(Compensation_Sum_in));
  endfunction

  // Offer one beat, wait (bounded) for ready, let it be taken at the edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n;
    @(negedge clk);
    comp_valid = 1'b1;
    comp_data  = d;
    comp_last  = last;
    n = 0;
    while (!comp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    model_beat(d);
    #1 comp_valid = 1'b0;
    comp_last = 1'b0;
  endtask

  // Starts right after the accepting edge: 8 writes, done, then ready.
  task automatic check_drain(input string tag);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      chk({tag, "_we"}, int'(CACC_Write_enable), 1);
      chk({tag, "_sum"}, sum_out(), exp_arr[LANES-1-i]);
      chk({tag, "_rdy_lo"}, int'(comp_ready), 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_done_we"}, int'(CACC_Write_enable), 0);
    chk({tag, "_done_sum"}, sum_out(), 0);
    chk({tag, "_done_busy"}, int'(busy), 1);
    chk({tag, "_done_rdy"}, int'(comp_ready), 0);
    @(negedge clk);
    chk({tag, "_rdy_back"}, int'(comp_ready), 1);
    chk({tag, "_done_gone"}, int'(done), 0);
    chk({tag, "_busy_gone"}, int'(busy), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, int'(comp_ready), 1);
    chk({tag, "_we"}, int'(CACC_Write_enable), 0);
    chk({tag, "_sum"}, sum_out(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [95:0]   r;
    int            nb;

    tbl[0] = '{"ramp1",   1,    1, 1,     1, 1};
    tbl[1] = '{"x3_100",  3,  100, 0,   300, 0};
    tbl[2] = '{"satpos", 20,  255, 0,  4095, 0};
    tbl[3] = '{"satneg", 20, -256, 0, -4096, 0};
    tbl[4] = '{"mixed",   2,  -10, 3,   -20, 6};

    rst = 1'b0; comp_valid = 1'b0; comp_last = 1'b0; comp_data = '0; clear = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b1;

    // Table-driven tiles with hand-computed expectations.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < tbl[v].nbeats; b++)
        send_beat(pack_ramp(tbl[v].base, tbl[v].step), b == tbl[v].nbeats - 1);
      for (int i = 0; i < LANES; i++) exp_arr[i] = tbl[v].exp_base + tbl[v].exp_step * i;
      model_zero();
      check_drain(tbl[v].name);
    end

    // clear on the 4th drain cycle: four writes, no done, next tile from zero.
    send_beat(pack_ramp(5, 1), 1'b1);
    expect_from_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_we", int'(CACC_Write_enable), 1);
      chk("clr_sum", sum_out(), exp_arr[LANES-1-i]);
    end
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check_idle("clr_after");
    @(negedge clk);
    chk("clr_no_done", int'(done), 0);
    send_beat(pack_ramp(1, 1), 1'b1);
    expect_from_model();
    check_drain("clr_next");

    // clear together with an offered beat: the beat is dropped.
    @(negedge clk);
    comp_valid = 1'b1; comp_last = 1'b1; comp_data = pack_ramp(200, 0); clear = 1'b1;
    @(posedge clk);
    #1 comp_valid = 1'b0; comp_last = 1'b0; clear = 1'b0;
    @(negedge clk);
    check_idle("clr_beat");
    send_beat(pack_ramp(-3, -1), 1'b1);
    expect_from_model();
    check_drain("clr_beat_next");

    // Reset in ACC after two beats: next tile drains only its own values.
    send_beat(pack_ramp(50, 2), 1'b0);
    send_beat(pack_ramp(50, 2), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_zero();
    @(negedge clk);
    check_idle("rst_acc");
    send_beat(pack_ramp(7, -2), 1'b1);
    expect_from_model();
    check_drain("rst_acc_next");

    // Reset in the middle of a drain stops the writes at once.
    send_beat(pack_ramp(9, 0), 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_drn_we", int'(CACC_Write_enable), 1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_zero();
    @(negedge clk);
    check_idle("rst_drn");

    // valid held high with random data through the drain.
    send_beat(pack_ramp(11, 1), 1'b1);
    r = {$urandom(), $urandom(), $urandom()};
    d = r[DW-1:0];
    comp_valid = 1'b1; comp_last = 1'b0; comp_data = d;
    expect_from_model();
    check_drain("held");
    @(posedge clk);
    model_beat(d);
    #1 comp_valid = 1'b0;
    send_beat(pack_ramp(-1, 0), 1'b1);
    expect_from_model();
    check_drain("held_next");

    // Random tiles against the reference model.
    for (int t = 0; t < 20; t++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        r = {$urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(r[DW-1:0], b == nb - 1);
      end
      expect_from_model();
      check_drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
